// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
//   - 3-bit opcode encodings understood by the external alu32
//   - command record stored in the command FIFO (a, b, op = 67 bits)
//   - issue FSM state encoding
package alu_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam int unsigned DataW = 32;
  localparam int unsigned CmdW  = 2 * DataW + 3;

  typedef struct packed {
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
    logic [2:0]       op;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Only arithmetic opcodes produce a meaningful overflow flag.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO for the ALU issue controller.
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous active-high reset, empties the FIFO
//     push_i   write wdata_i (ignored while full)
//     wdata_i  command record {a, b, op}
//     pop_i    drop head entry (ignored while empty)
//     rdata_o  head entry, valid while !empty_o
//     full_o   no free entry
//     empty_o  no stored entry
//     count_o  occupancy, 0..Depth
//   Depth must be a power of two so that pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  cmd_t                     wdata_i,
  input  logic                     pop_i,
  output cmd_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  cmd_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say so.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, issues them one at a time to an
// external alu32 and returns the result plus flags through a valid/ready
// response port.
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     cmd_valid/cmd_ready         command handshake; cmd_ready = FIFO not full
//     cmd_a, cmd_b, cmd_op        command operands and opcode
//     alu_a, alu_b, alu_op        registered operands driven to alu32
//     alu_result, alu_c/n/z/v     alu32 outputs, sampled one cycle after issue
//     rsp_valid/rsp_ready         response handshake
//     rsp_result, rsp_c/n/z/v     captured result and flags
//     cmd_count                   FIFO occupancy
//     busy                        FSM active or commands queued
//     clr_sticky, sticky_v        accumulated arithmetic overflow
//   Build option: define ALU_STICKY_FLAGS_EN to implement sticky_v; otherwise
//   sticky_v is tied low and clr_sticky is ignored.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [31:0]                   cmd_a,
  input  logic [31:0]                   cmd_b,
  input  logic [2:0]                    cmd_op,
  output logic [31:0]                   alu_a,
  output logic [31:0]                   alu_b,
  output logic [2:0]                    alu_op,
  input  logic [31:0]                   alu_result,
  input  logic                          alu_c,
  input  logic                          alu_n,
  input  logic                          alu_z,
  input  logic                          alu_v,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_result,
  output logic                          rsp_c,
  output logic                          rsp_n,
  output logic                          rsp_z,
  output logic                          rsp_v,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic                          busy,
  input  logic                          clr_sticky,
  output logic                          sticky_v
);

  state_e      state_q;
  cmd_t        fifo_wdata;
  cmd_t        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  alu_op_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic        rsp_c_q, rsp_n_q, rsp_z_q, rsp_v_q;

  assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: cmd_op};

  alu_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cmd_count)
  );

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign cmd_ready = !fifo_full;

  // Pop whenever the FSM is about to load a new command into the ALU registers.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle:  fifo_pop = !fifo_empty;
      StResp:  fifo_pop = rsp_valid_q && rsp_ready && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // Issue FSM: IDLE -> EXEC (alu32 settles) -> RESP (hold until consumed).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_NOTA;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            alu_a_q  <= fifo_head.a;
            alu_b_q  <= fifo_head.b;
            alu_op_q <= fifo_head.op;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= alu_result;
          rsp_c_q      <= alu_c;
          rsp_n_q      <= alu_n;
          rsp_z_q      <= alu_z;
          rsp_v_q      <= alu_v;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // Chain straight into the next command to sustain 2 cycles/response.
            if (!fifo_empty) begin
              alu_a_q  <= fifo_head.a;
              alu_b_q  <= fifo_head.b;
              alu_op_q <= fifo_head.op;
              state_q  <= StExec;
            end else begin
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_n      = rsp_n_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_v      = rsp_v_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_q, sticky_d;

  // Set takes priority over a simultaneous clear so no overflow is lost.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if ((state_q == StExec) && is_arith(alu_op_q) && alu_v) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
`ifdef ALU_STICKY_FLAGS_EN
  localparam logic StickyEn = 1'b1;
`else
  localparam logic StickyEn = 1'b0;
`endif

  logic                        clk;
  logic                        reset;
  logic                        cmd_valid, cmd_ready;
  logic [31:0]                 cmd_a, cmd_b;
  logic [2:0]                  cmd_op;
  logic [31:0]                 alu_a, alu_b;
  logic [2:0]                  alu_op;
  logic [31:0]                 alu_result;
  logic                        alu_c, alu_n, alu_z, alu_v;
  logic                        rsp_valid, rsp_ready;
  logic [31:0]                 rsp_result;
  logic                        rsp_c, rsp_n, rsp_z, rsp_v;
  logic [$clog2(FIFO_DEPTH):0] cmd_count;
  logic                        busy;
  logic                        clr_sticky, sticky_v;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        n;
    logic        z;
    logic        v;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          rsp_cnt = 0;
  int          acc_cnt = 0;
  rsp_t        sb_q[$];
  int unsigned hs_cyc[$];

  alu_issue_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_c      (rsp_c),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z),
    .rsp_v      (rsp_v),
    .cmd_count  (cmd_count),
    .busy       (busy),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  // Reference alu32 behaviour; also stands in for the external alu32.
  function automatic rsp_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
    rsp_t        o;
    logic [32:0] s;
    o = '0;
    case (op)
      OP_NOTA: o.r = ~a;
      OP_NOTB: o.r = ~b;
      OP_AND:  o.r = a & b;
      OP_OR:   o.r = a | b;
      OP_XOR:  o.r = a ^ b;
      OP_XNOR: o.r = ~(a ^ b);
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      default: begin
        o.r = a - b;
        o.c = (a >= b);
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
    endcase
    o.n = o.r[31];
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  always_comb begin
    {alu_result, alu_c, alu_n, alu_z, alu_v} = alu_ref(alu_a, alu_b, alu_op);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted command, pop and compare on consumed response.
  always @(negedge clk) begin
    rsp_t e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        hs_cyc.push_back(cyc);
        chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_result", rsp_result, e.r);
          chk("sb_flags", 32'({rsp_c, rsp_n, rsp_z, rsp_v}), 32'({e.c, e.n, e.z, e.v}));
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back(alu_ref(cmd_a, cmd_b, cmd_op));
        acc_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  initial begin
    int   base_rsp;
    int   base_acc;
    rsp_t e0;
    logic [31:0] ta [6];
    logic [31:0] tb [6];

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) tick();

    // Reset state.
    @(negedge clk);
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp", rsp_result, 32'd0);
    chk("rst_flags", 32'({rsp_c, rsp_n, rsp_z, rsp_v}), 32'd0);
    chk("rst_sticky", 32'(sticky_v), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // ADD overflow with latency check: push E0, pop E1, response after E2.
    rsp_ready = 1'b1;
    drive(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat_e0_count", 32'(cmd_count), 32'd1);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    chk("lat_e0_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("lat_e1_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("lat_e1_alu_b", alu_b, 32'h0000_0001);
    chk("lat_e1_alu_op", 32'(alu_op), 32'(OP_ADD));
    chk("lat_e1_count", 32'(cmd_count), 32'd0);
    chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'h8000_0000);
    chk("add_cnzv", 32'({rsp_c, rsp_n, rsp_z, rsp_v}), 32'b0101);
    chk("add_sticky", 32'(sticky_v), 32'(StickyEn));
    repeat (2) tick();
    @(negedge clk);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // SUB equal operands: zero with no-borrow carry.
    drive(32'd5, 32'd5, OP_SUB);
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("sub_valid", 32'(rsp_valid), 32'd1);
    chk("sub_result", rsp_result, 32'd0);
    chk("sub_cnzv", 32'({rsp_c, rsp_n, rsp_z, rsp_v}), 32'b1010);
    repeat (2) tick();

    // Non-overflowing ADD keeps sticky; clear pulse drops it.
    drive(32'd1, 32'd2, OP_ADD);
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("sticky_hold", 32'(sticky_v), 32'(StickyEn));
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clr", 32'(sticky_v), 32'd0);

    // Back-pressure: six offers, five accepted, FIFO full.
    rsp_ready = 1'b0;
    base_acc  = acc_cnt;
    base_rsp  = rsp_cnt;
    for (int i = 0; i < 6; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
    end
    e0 = alu_ref(ta[0], tb[0], 3'(0));
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb[i], 3'(i));
      tick();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(acc_cnt - base_acc), 32'd5);
    chk("bp_count", 32'(cmd_count), 32'd4);
    chk("bp_ready", 32'(cmd_ready), 32'd0);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head_result", rsp_result, e0.r);
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && (rsp_cnt - base_rsp) < 5; k++) tick();
    chk("bp_drained", 32'(rsp_cnt - base_rsp), 32'd5);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) tick();

    // Throughput: three back-to-back commands, one response every 2 cycles.
    hs_cyc.delete();
    base_rsp = rsp_cnt;
    drive($urandom, $urandom, OP_ADD);
    tick();
    drive($urandom, $urandom, OP_SUB);
    tick();
    drive($urandom, $urandom, OP_XOR);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && (rsp_cnt - base_rsp) < 3; k++) tick();
    chk("tp_count", 32'(rsp_cnt - base_rsp), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("tp_gap01", hs_cyc[1] - hs_cyc[0], 32'd2);
      chk("tp_gap12", hs_cyc[2] - hs_cyc[1], 32'd2);
    end
    repeat (2) tick();

    // Reset while in EXEC with two commands queued.
    rsp_ready = 1'b0;
    drive(32'h11, 32'h22, OP_ADD);
    tick();
    drive(32'h33, 32'h44, OP_OR);
    tick();
    drive(32'h55, 32'h66, OP_AND);
    tick();
    rsp_ready = 1'b1;
    drive(32'h77, 32'h88, OP_SUB);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", 32'(cmd_count), 32'd2);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd0);
    chk("pre_rst_alu_a", alu_a, 32'h33);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(cmd_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    base_rsp  = rsp_cnt;
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("no_stale_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 Ports shall be as follows, clock and reset first:
 clk  in  1  rising-edge clock, sole clock domain.
 reset  in  1  synchronous active-high reset.
 cmd_valid  in  1  command offered.
 cmd_ready  out  1  command accepted when high with cmd_valid.
 cmd_a, cmd_b  in  32  operands.
 cmd_op  in  3  ALU opcode.
 alu_a, alu_b  out  32  operands driven to alu32.
 alu_op  out  3  opcode driven to alu32.
 alu_result  in  32  alu32 result.
 alu_c, alu_n, alu_z, alu_v  in  1  alu32 flags.
 rsp_valid  out  1  response available.
 rsp_ready  in  1  response consumed when high with rsp_valid.
 rsp_result  out  32  captured result.
 rsp_c, rsp_n, rsp_z, rsp_v  out  1  captured flags.
 cmd_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
 busy  out  1  high when FSM not IDLE or FIFO non-empty.
 clr_sticky  in  1  clears sticky_v (configuration-dependent).
 sticky_v  out  1  accumulated overflow (configuration-dependent).

Function
REQ-003 Push on edge with cmd_valid&&cmd_ready; cmd_ready = !full, independent of same-cycle pop (no push while full).
REQ-004 FIFO shall be first-in first-out; responses leave in command order, none dropped or duplicated.
REQ-005 FSM states: IDLE, EXEC, RESP.
REQ-006 IDLE: FIFO non-empty -> pop head into alu_a/alu_b/alu_op registers, go EXEC; else stay.
REQ-007 EXEC: one cycle for alu32 settling; at exit edge capture alu_result and four flags into rsp_* registers, set rsp_valid, go RESP.
REQ-008 RESP: hold rsp_* stable until rsp_valid&&rsp_ready; on that edge clear rsp_valid; FIFO non-empty -> pop and go EXEC directly, else go IDLE.
REQ-009 Latency: command pushed into empty FIFO with FSM IDLE at edge E0 -> popped at E1, rsp_valid high after E2; sustained throughput one response per 2 cycles with rsp_ready held high.
REQ-010 alu_a/alu_b/alu_op shall be registered and change only on pop edges.
REQ-011 Flags pass through unmodified for every opcode; ADD=110, SUB=111 (SUB carry = no-borrow).
REQ-012 cmd_count increments on push-only, decrements on pop-only, unchanged on simultaneous push and pop; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-013 On reset edge: FSM IDLE, FIFO emptied, cmd_count 0, rsp_valid 0, rsp_result/flags 0, alu_a/alu_b 0, alu_op 000, busy 0, sticky_v 0.
REQ-014 Reset during EXEC or RESP discards the in-flight command; no response issued for it.
REQ-015 cmd_ready shall be 1 in the first cycle after reset.

Configuration
REQ-016 Macro ALU_STICKY_FLAGS_EN defined: sticky_v set at capture edge when alu_op is 110/111 and alu_v=1; cleared by clr_sticky; set wins over simultaneous clr_sticky.
REQ-017 Macro undefined: sticky_v constant 0, clr_sticky ignored, no sticky register.

Structure
REQ-018 Shared package alu_pkg holds opcode constants (OP_NOTA=000, OP_NOTB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_XNOR=101, OP_ADD=110, OP_SUB=111) and FSM state encoding.
REQ-019 Command storage shall be sub-module alu_cmd_fifo (67-bit entries: a, b, op); FSM and capture registers in alu_issue_ctrl; alu32 instantiated externally.

Verification
REQ-020 ADD 0x7FFFFFFF+0x00000001 -> rsp_result 0x80000000, n=1, v=1, c=0, z=0, rsp_valid after E2.
REQ-021 SUB 0x00000005-0x00000005 -> rsp_result 0, z=1, c=1, v=0, n=0.
REQ-022 rsp_ready=0, offer 6 commands -> 5 accepted (1 in flight, 4 queued), cmd_count=4, cmd_ready=0; then rsp_ready=1 -> 5 responses in order.
REQ-023 rsp_ready held 1, 3 back-to-back commands -> rsp_valid pulses at 2-cycle spacing, results in order.
REQ-024 Reset asserted in EXEC with 2 queued -> next cycle rsp_valid=0, cmd_count=0, cmd_ready=1, no stale response after release.
REQ-025 ALU_STICKY_FLAGS_EN: overflowing ADD then non-overflowing ADD -> sticky_v stays 1; clr_sticky pulse -> 0; macro undefined -> sticky_v always 0.
